p2s_tx: RTL and testbench



---
 rtl/p2s_pkg.sv | 31 +++
 rtl/p2s_bitclk.sv | 54 +++++
 rtl/p2s_tx.sv | 186 ++++++++++++++++++
 tb/tb_p2s_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/p2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : p2s_pkg
//  Description : Shared constants, state encoding and the header-escape
//                helper for the p2s_tx serial frame transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package p2s_pkg;

  localparam int DW     = 14;
  localparam int NUM_CH = 4;

  // Header opens every frame; data equal to it would alias a frame start.
  localparam logic [DW-1:0] HDR_WORD = 14'h0FFF;
  // Substitute value sent in place of a data word that equals the header.
  localparam logic [DW-1:0] ESC_WORD = 14'h0FFE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Replace a header-valued data word with the escape word.
  function automatic logic [DW-1:0] escape_word(input logic [DW-1:0] w);
    return (w == HDR_WORD) ? ESC_WORD : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/p2s_bitclk.sv
`default_nettype none
// ============================================================================
//  Module      : p2s_bitclk
//  Description : Bit-period prescaler. Each bit lasts 2*CLK_DIV cycles:
//                sck low for CLK_DIV cycles, then high for CLK_DIV cycles.
//                bit_start_o marks the first cycle of a bit, bit_end_o the
//                last. Counter is held at zero whenever en_i is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module p2s_bitclk #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sck_o,
  output logic bit_start_o,
  output logic bit_end_o
);

  localparam int            CW   = $clog2(2 * CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Advance the phase counter while enabled, wrap at the end of each bit.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Phase counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sck_o       = en_i && (cnt_q >= HALF);
  assign bit_start_o = en_i && (cnt_q == '0);
  assign bit_end_o   = en_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/p2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : p2s_tx
//  Description : Parallel-to-serial frame transmitter. On start, snapshots
//                four 14-bit channel samples and sends a frame of five words
//                (header 14'h0FFF, then ch1..ch4), MSB first, each word in
//                its own cs-low window followed by CS_GAP idle cycles.
//                Optional feature macro: P2S_ESCAPE_EN - data words equal to
//                the header are sent as 14'h0FFE and counted in clamp_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module p2s_tx
  import p2s_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] ch1,
  input  logic [DW-1:0] ch2,
  input  logic [DW-1:0] ch3,
  input  logic [DW-1:0] ch4,
  output logic          busy,
  output logic          done,
  output logic          mosi,
  output logic          sck,
  output logic          cs,
  output logic [7:0]    clamp_cnt
);

  localparam int            GW       = $clog2(CS_GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
  localparam logic [3:0]    NUM_BITS = 4'(DW);
  localparam logic [2:0]    LAST_IDX = 3'(NUM_CH);

  state_t                      state_q, state_d;
  logic [DW-1:0]               shreg_q, shreg_d;
  logic [3:0]                  bit_q, bit_d;     // bits started in this word
  logic [2:0]                  idx_q, idx_d;     // 0 = header, 1..4 = channel
  logic [GW-1:0]               gap_q, gap_d;
  logic [NUM_CH-1:0][DW-1:0]   shadow_q, shadow_d;

  logic                        w_shift_en;
  logic                        w_sck;
  logic                        w_bit_start;
  logic                        w_bit_end;
  logic [DW-1:0]               w_next_raw;

`ifdef P2S_ESCAPE_EN
  logic                        clamp_flag_q, clamp_flag_d;
  logic [7:0]                  clamp_cnt_q, clamp_cnt_d;
`endif

  assign w_shift_en = (state_q == SHIFT);
  // Shadow slot for the word that follows index idx_q (channel idx_q+1).
  assign w_next_raw = shadow_q[idx_q[1:0]];

  p2s_bitclk #(
    .CLK_DIV (CLK_DIV)
  ) u_bitclk (
    .clk         (clk),
    .rst         (rst),
    .en_i        (w_shift_en),
    .sck_o       (w_sck),
    .bit_start_o (w_bit_start),
    .bit_end_o   (w_bit_end)
  );

  // Next-state logic for the frame FSM and its datapath.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    shadow_d = shadow_q;
`ifdef P2S_ESCAPE_EN
    clamp_flag_d = clamp_flag_q;
    clamp_cnt_d  = clamp_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = {ch4, ch3, ch2, ch1};
          shreg_d  = HDR_WORD;
          bit_d    = '0;
          idx_d    = '0;
          state_d  = SHIFT;
`ifdef P2S_ESCAPE_EN
          clamp_flag_d = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (w_bit_start) begin
          bit_d = bit_q + 4'd1;
        end
        if (w_bit_end) begin
          if (bit_q == NUM_BITS) begin
            // Last bit done: cs rises on the next cycle.
            gap_d   = '0;
            state_d = GAP;
`ifdef P2S_ESCAPE_EN
            if (clamp_flag_q && (clamp_cnt_q != 8'hFF)) begin
              clamp_cnt_d = clamp_cnt_q + 8'd1;
            end
`endif
          end else begin
            // New bit is presented while sck is low.
            shreg_d = {shreg_q[DW-2:0], 1'b0};
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            bit_d   = '0;
            state_d = SHIFT;
`ifdef P2S_ESCAPE_EN
            shreg_d      = escape_word(w_next_raw);
            clamp_flag_d = (w_next_raw == HDR_WORD);
`else
            shreg_d      = w_next_raw;
`endif
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bit_q    <= '0;
      idx_q    <= '0;
      gap_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      shadow_q <= shadow_d;
    end
  end

`ifdef P2S_ESCAPE_EN
  // Escape bookkeeping: per-word clamp flag and saturating clamp counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      clamp_flag_q <= 1'b0;
      clamp_cnt_q  <= '0;
    end else begin
      clamp_flag_q <= clamp_flag_d;
      clamp_cnt_q  <= clamp_cnt_d;
    end
  end
  assign clamp_cnt = clamp_cnt_q;
`else
  assign clamp_cnt = '0;
`endif

  assign busy = (state_q == SHIFT) || (state_q == GAP);
  assign done = (state_q == DONE);
  assign cs   = (state_q != SHIFT);
  assign sck  = w_sck;
  assign mosi = w_shift_en && shreg_q[DW-1];

endmodule
`default_nettype wire

// File: tb/tb_p2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_p2s_tx
//  Description : Self-checking bench for p2s_tx. Instance A uses default
//                timing, instance B uses CLK_DIV=1/CS_GAP=1. Each instance
//                has a receiver model that reassembles words from sck/mosi
//                and closes a word on each cs rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_p2s_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Instance A (defaults)
  logic        start_a;
  logic [13:0] c1_a, c2_a, c3_a, c4_a;
  logic        busy_a, done_a, mosi_a, sck_a, cs_a;
  logic [7:0]  clamp_a;

  // Instance B (fast)
  logic        start_b;
  logic [13:0] c1_b, c2_b, c3_b, c4_b;
  logic        busy_b, done_b, mosi_b, sck_b, cs_b;
  logic [7:0]  clamp_b;

  p2s_tx u_dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .ch1(c1_a), .ch2(c2_a), .ch3(c3_a), .ch4(c4_a),
    .busy(busy_a), .done(done_a), .mosi(mosi_a), .sck(sck_a), .cs(cs_a),
    .clamp_cnt(clamp_a)
  );

  p2s_tx #(.CLK_DIV(1), .CS_GAP(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .ch1(c1_b), .ch2(c2_b), .ch3(c3_b), .ch4(c4_b),
    .busy(busy_b), .done(done_b), .mosi(mosi_b), .sck(sck_b), .cs(cs_b),
    .clamp_cnt(clamp_b)
  );

  // Receiver model A
  logic [13:0] q_a[$];
  int          nb_a[$];
  logic [13:0] sh_a = '0;
  int          bits_a = 0, stray_a = 0;
  logic        psck_a = 1'b0, pcs_a = 1'b1;

  always @(negedge clk) begin
    if (sck_a === 1'b1 && psck_a === 1'b0) begin
      if (cs_a === 1'b1) stray_a++;
      else begin sh_a = {sh_a[12:0], mosi_a}; bits_a++; end
    end
    if (cs_a === 1'b0 && pcs_a === 1'b1) bits_a = 0;
    if (cs_a === 1'b1 && pcs_a === 1'b0) begin
      q_a.push_back(sh_a); nb_a.push_back(bits_a); bits_a = 0;
    end
    psck_a = sck_a; pcs_a = cs_a;
  end

  // Receiver model B, plus sck duty tally inside cs-low windows
  logic [13:0] q_b[$];
  int          nb_b[$];
  logic [13:0] sh_b = '0;
  int          bits_b = 0, stray_b = 0, hi_b = 0, lo_b = 0;
  logic        psck_b = 1'b0, pcs_b = 1'b1;

  always @(negedge clk) begin
    if (cs_b === 1'b0) begin
      if (sck_b === 1'b1) hi_b++; else lo_b++;
    end
    if (sck_b === 1'b1 && psck_b === 1'b0) begin
      if (cs_b === 1'b1) stray_b++;
      else begin sh_b = {sh_b[12:0], mosi_b}; bits_b++; end
    end
    if (cs_b === 1'b0 && pcs_b === 1'b1) bits_b = 0;
    if (cs_b === 1'b1 && pcs_b === 1'b0) begin
      q_b.push_back(sh_b); nb_b.push_back(bits_b); bits_b = 0;
    end
    psck_b = sck_b; pcs_b = cs_b;
  end

  // Issue a one-cycle start on A and wait (bounded) for done; lat = cycles
  // from accept to done, or -1 on timeout.
  task automatic run_frame_a(input logic [13:0] w1, w2, w3, w4, output int lat);
    c1_a = w1; c2_a = w2; c3_a = w3; c4_a = w4;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    lat = 1;
    while (done_a !== 1'b1 && lat < 2000) begin @(negedge clk); lat++; end
    if (done_a !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    int bad;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++; if (cs_a !== 1'b1)   $display("FAIL reset_cs: got %b want 1", cs_a); else pass_cnt++;
    chk_cnt++; if (sck_a !== 1'b0)  $display("FAIL reset_sck: got %b want 0", sck_a); else pass_cnt++;
    chk_cnt++; if (mosi_a !== 1'b0) $display("FAIL reset_mosi: got %b want 0", mosi_a); else pass_cnt++;
    chk_cnt++; if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL reset_busy_done: got %b%b want 00", busy_a, done_a); else pass_cnt++;
    chk_cnt++; if (clamp_a !== 8'd0) $display("FAIL reset_clamp: got %0d want 0", clamp_a); else pass_cnt++;
    chk_cnt++; if (cs_b !== 1'b1 || busy_b !== 1'b0) $display("FAIL reset_b: got cs=%b busy=%b want 1/0", cs_b, busy_b); else pass_cnt++;
    rst = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (cs_a !== 1'b1 || sck_a !== 1'b0 || mosi_a !== 1'b0 || busy_a !== 1'b0) bad++;
    end
    chk_cnt++; if (bad != 0) $display("FAIL idle_levels: got %0d bad cycles want 0", bad); else pass_cnt++;
    chk_cnt++; if (stray_a != 0 || q_a.size() != 0) $display("FAIL idle_sck: got stray=%0d words=%0d want 0/0", stray_a, q_a.size()); else pass_cnt++;
  endtask

  task automatic test_frame;
    logic [13:0] exp [5];
    int k;
    exp = '{14'h0FFF, 14'h0001, 14'h1234, 14'h3FFF, 14'h0000};
    q_a.delete(); nb_a.delete();
    c1_a = 14'h0001; c2_a = 14'h1234; c3_a = 14'h3FFF; c4_a = 14'h0000;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk_cnt++; if (busy_a !== 1'b1 || cs_a !== 1'b0) $display("FAIL accept_next: got busy=%b cs=%b want 1/0", busy_a, cs_a); else pass_cnt++;
    chk_cnt++; if (mosi_a !== 1'b0 || sck_a !== 1'b0) $display("FAIL first_bit: got mosi=%b sck=%b want 0/0", mosi_a, sck_a); else pass_cnt++;
    k = 1;
    while (done_a !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
    chk_cnt++; if (k != 601) $display("FAIL done_latency: got %0d want 601", k); else pass_cnt++;
    chk_cnt++; if (busy_a !== 1'b0) $display("FAIL busy_at_done: got %b want 0", busy_a); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (done_a !== 1'b0) $display("FAIL done_pulse: got %b want 0", done_a); else pass_cnt++;
    chk_cnt++; if (q_a.size() != 5) $display("FAIL frame_words: got %0d want 5", q_a.size()); else pass_cnt++;
    for (int i = 0; i < 5 && i < q_a.size(); i++) begin
      chk_cnt++; if (q_a[i] !== exp[i]) $display("FAIL frame_word%0d: got %h want %h", i, q_a[i], exp[i]); else pass_cnt++;
      chk_cnt++; if (nb_a[i] != 14) $display("FAIL frame_sck%0d: got %0d rises want 14", i, nb_a[i]); else pass_cnt++;
    end
  endtask

  task automatic test_ignore;
    logic [13:0] exp [5];
    int k, extra;
    exp = '{14'h0FFF, 14'h2AAA, 14'h1555, 14'h0ABC, 14'h3000};
    q_a.delete(); nb_a.delete();
    c1_a = exp[1]; c2_a = exp[2]; c3_a = exp[3]; c4_a = exp[4];
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    k = 1;
    while (done_a !== 1'b1 && k < 2000) begin
      @(negedge clk); k++;
      if (k == 100) start_a = 1'b1;
      if (k == 101) start_a = 1'b0;
      if (k == 200) begin c1_a = 14'h0FFF; c2_a = 14'h0000; c3_a = 14'h3FFF; c4_a = 14'h0001; end
    end
    chk_cnt++; if (k != 601) $display("FAIL ignore_latency: got %0d want 601", k); else pass_cnt++;
    start_a = 1'b1;            // present during DONE only
    @(negedge clk);
    start_a = 1'b0;
    extra = 0;
    repeat (700) begin @(negedge clk); if (busy_a !== 1'b0 || done_a !== 1'b0) extra++; end
    chk_cnt++; if (extra != 0) $display("FAIL ignore_second_frame: got %0d busy cycles want 0", extra); else pass_cnt++;
    chk_cnt++; if (q_a.size() != 5) $display("FAIL ignore_words: got %0d want 5", q_a.size()); else pass_cnt++;
    for (int i = 0; i < 5 && i < q_a.size(); i++) begin
      chk_cnt++; if (q_a[i] !== exp[i]) $display("FAIL ignore_word%0d: got %h want %h", i, q_a[i], exp[i]); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid;
    logic [13:0] exp [5];
    int k, dn, lat;
    exp = '{14'h0FFF, 14'h0101, 14'h0202, 14'h0303, 14'h0404};
    c1_a = 14'h1111; c2_a = 14'h2222; c3_a = 14'h3333; c4_a = 14'h0444;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    k = 1;
    while (k < 300) begin @(negedge clk); k++; end
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++; if (cs_a !== 1'b1 || sck_a !== 1'b0 || mosi_a !== 1'b0) $display("FAIL midrst_lines: got cs=%b sck=%b mosi=%b want 1/0/0", cs_a, sck_a, mosi_a); else pass_cnt++;
    chk_cnt++; if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL midrst_busy_done: got %b%b want 00", busy_a, done_a); else pass_cnt++;
    rst = 1'b0;
    dn = 0;
    repeat (400) begin @(negedge clk); if (done_a === 1'b1 || busy_a === 1'b1) dn++; end
    chk_cnt++; if (dn != 0) $display("FAIL midrst_no_done: got %0d active cycles want 0", dn); else pass_cnt++;
    q_a.delete(); nb_a.delete();
    run_frame_a(exp[1], exp[2], exp[3], exp[4], lat);
    chk_cnt++; if (lat != 601) $display("FAIL midrst_relaunch: got %0d want 601", lat); else pass_cnt++;
    repeat (2) @(negedge clk);
    chk_cnt++; if (q_a.size() != 5) $display("FAIL midrst_words: got %0d want 5", q_a.size()); else pass_cnt++;
    for (int i = 0; i < 5 && i < q_a.size(); i++) begin
      chk_cnt++; if (q_a[i] !== exp[i] || nb_a[i] != 14) $display("FAIL midrst_word%0d: got %h/%0d want %h/14", i, q_a[i], nb_a[i], exp[i]); else pass_cnt++;
    end
  endtask

  task automatic test_escape;
    logic [13:0] w2;
    logic [7:0]  c1, c3;
    int lat;
`ifdef P2S_ESCAPE_EN
    w2 = 14'h0FFE; c1 = 8'd1; c3 = 8'd3;
`else
    w2 = 14'h0FFF; c1 = 8'd0; c3 = 8'd0;
`endif
    chk_cnt++; if (clamp_a !== 8'd0) $display("FAIL esc_clamp_pre: got %0d want 0", clamp_a); else pass_cnt++;
    q_a.delete(); nb_a.delete();
    run_frame_a(14'h0123, 14'h0FFF, 14'h0FFE, 14'h3FFF, lat);
    repeat (2) @(negedge clk);
    chk_cnt++; if (q_a.size() != 5) $display("FAIL esc_words: got %0d want 5", q_a.size()); else pass_cnt++;
    if (q_a.size() == 5) begin
      chk_cnt++; if (q_a[2] !== w2) $display("FAIL esc_ch2: got %h want %h", q_a[2], w2); else pass_cnt++;
      chk_cnt++; if (q_a[3] !== 14'h0FFE) $display("FAIL esc_ch3: got %h want 0ffe", q_a[3]); else pass_cnt++;
    end
    chk_cnt++; if (clamp_a !== c1) $display("FAIL esc_clamp1: got %0d want %0d", clamp_a, c1); else pass_cnt++;
    run_frame_a(14'h0FFF, 14'h0001, 14'h0FFF, 14'h0002, lat);
    repeat (2) @(negedge clk);
    chk_cnt++; if (clamp_a !== c3) $display("FAIL esc_clamp3: got %0d want %0d", clamp_a, c3); else pass_cnt++;
    chk_cnt++; if (stray_a != 0) $display("FAIL stray_sck_a: got %0d want 0", stray_a); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [13:0] exp [5];
    int k, nd, t [3], bad;
    exp = '{14'h0FFF, 14'h2AAA, 14'h1555, 14'h0001, 14'h3FFE};
    q_b.delete(); nb_b.delete(); hi_b = 0; lo_b = 0;
    c1_b = exp[1]; c2_b = exp[2]; c3_b = exp[3]; c4_b = exp[4];
    start_b = 1'b1;
    k = 0; nd = 0;
    while (nd < 3 && k < 1000) begin
      @(negedge clk); k++;
      if (done_b === 1'b1) begin t[nd] = k; nd++; end
    end
    start_b = 1'b0;
    chk_cnt++; if (nd != 3) $display("FAIL b2b_done_count: got %0d want 3", nd); else pass_cnt++;
    if (nd == 3) begin
      chk_cnt++; if (t[0] != 146) $display("FAIL b2b_first_done: got %0d want 146", t[0]); else pass_cnt++;
      chk_cnt++; if (t[1] - t[0] != 147 || t[2] - t[1] != 147) $display("FAIL b2b_period: got %0d/%0d want 147", t[1] - t[0], t[2] - t[1]); else pass_cnt++;
    end
    repeat (200) @(negedge clk);
    chk_cnt++; if (busy_b !== 1'b0) $display("FAIL b2b_stopped: got busy=%b want 0", busy_b); else pass_cnt++;
    chk_cnt++; if (q_b.size() != 15) $display("FAIL b2b_words: got %0d want 15", q_b.size()); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < q_b.size(); i++) if (q_b[i] !== exp[i % 5] || nb_b[i] != 14) bad++;
    chk_cnt++; if (bad != 0) $display("FAIL b2b_word_content: got %0d bad words want 0", bad); else pass_cnt++;
    chk_cnt++; if (hi_b != 210 || lo_b != 210) $display("FAIL b2b_duty: got hi=%0d lo=%0d want 210/210", hi_b, lo_b); else pass_cnt++;
    chk_cnt++; if (stray_b != 0) $display("FAIL stray_sck_b: got %0d want 0", stray_b); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    c1_a = '0; c2_a = '0; c3_a = '0; c4_a = '0;
    c1_b = '0; c2_b = '0; c3_b = '0; c4_b = '0;
    @(negedge clk);
    test_reset;
    test_frame;
    test_ignore;
    test_reset_mid;
    test_escape;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
